// File: rtl/audio_sample_streamer_pkg.sv
// Shared types and defaults for the audio sample streamer slice.
package audio_stream_pkg;

  localparam int DEF_ADDR_W   = 18;
  localparam int DEF_SAMPLE_W = 16;

  typedef logic [DEF_SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

endpackage

// File: rtl/audio_sample_streamer_if.sv
// Memory read bus and sample stream bundled between the streamer and its peers.
// master = streamer side, slave = memory/serializer side.
interface audio_sample_streamer_if
  import audio_stream_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int SAMPLE_W = DEF_SAMPLE_W
);
  logic [ADDR_W-1:0]   mem_address;
  logic                mem_chipselect;
  logic [SAMPLE_W-1:0] mem_readdata;
  logic [SAMPLE_W-1:0] sample_data;
  logic                sample_valid;
  logic                sample_ready;

  modport master (
    output mem_address, mem_chipselect, sample_data, sample_valid,
    input  mem_readdata, sample_ready
  );

  modport slave (
    input  mem_address, mem_chipselect, sample_data, sample_valid,
    output mem_readdata, sample_ready
  );
endinterface

// File: rtl/audio_sample_streamer_sample_fifo.sv
// Small synchronous prefetch FIFO with push/pop/count and synchronous flush.
// Head reads as zero while empty so the stream data is clean outside playback.
module sample_fifo
  import audio_stream_pkg::*;
#(
  parameter int SAMPLE_W   = DEF_SAMPLE_W,
  parameter int FIFO_DEPTH = 4,
  localparam int PW        = $clog2(FIFO_DEPTH),
  localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_flush,
  input  logic                i_push,
  input  logic [SAMPLE_W-1:0] i_push_data,
  input  logic                i_pop,
  output logic [SAMPLE_W-1:0] o_head,
  output logic [CW-1:0]       o_count,
  output logic                o_empty
);

  logic [SAMPLE_W-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic                w_full;
  logic                w_do_push;
  logic                w_do_pop;

  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && (!w_full || i_pop);
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage write on accepted push.
  // NOTE: the data array has no reset; r_count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Pointer and occupancy bookkeeping; reset and flush both empty the FIFO.
  always_ff @(posedge clk) begin
    if (!reset_n || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/audio_sample_streamer.sv
// Sequential PCM sample reader feeding a valid/ready stream via a prefetch FIFO.
// Optional macro AUDIO_STREAMER_ATTENUATE_EN adds an arithmetic right-shift
// attenuation input applied to each sample as it enters the FIFO.
module audio_sample_streamer
  import audio_stream_pkg::*;
#(
  parameter int NUM_SAMPLES = 240255,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int SAMPLE_W    = DEF_SAMPLE_W,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic stop,
  input  logic loop_en,
`ifdef AUDIO_STREAMER_ATTENUATE_EN
  input  logic [2:0] attenuation,
`endif
  output logic busy,
  output logic done,
  audio_sample_streamer_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SAMPLES - 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic                r_inflight;
  logic                r_busy;
  logic                r_done;

  logic [CW-1:0]       w_count;
  logic                w_empty;
  logic [CW:0]         w_occupancy;
  logic                w_issue;
  logic                w_flush;
  logic                w_pop;
  logic [SAMPLE_W-1:0] w_push_data;

  // Occupancy uses the count before any same-cycle pop, so it never overfills.
  assign w_occupancy = {1'b0, w_count} + (CW+1)'(r_inflight);
  assign w_issue     = (r_state == FETCH) && (w_occupancy < (CW+1)'(FIFO_DEPTH));
  assign w_flush     = stop && (r_state != IDLE);
  assign w_pop       = bus.sample_ready && !w_empty;

`ifdef AUDIO_STREAMER_ATTENUATE_EN
  assign w_push_data = SAMPLE_W'($signed(bus.mem_readdata) >>> attenuation);
`else
  assign w_push_data = bus.mem_readdata;
`endif

  assign bus.mem_chipselect = w_issue;
  assign bus.mem_address    = r_ptr;
  assign bus.sample_valid   = !w_empty;
  assign busy               = r_busy;
  assign done               = r_done;

  sample_fifo #(
    .SAMPLE_W   (SAMPLE_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_flush     (w_flush),
    .i_push      (r_inflight),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (bus.sample_data),
    .o_count     (w_count),
    .o_empty     (w_empty)
  );

  // Playback FSM: pointer advance, in-flight tracking, busy/done flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_inflight <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      // NOTE: pulse/strobe registers get a default each cycle and are overridden below.
      r_done     <= 1'b0;
      r_inflight <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= FETCH;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        FETCH: begin
          if (stop) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_issue) begin
            r_inflight <= 1'b1;
            if (r_ptr == LAST_ADDR) begin
              r_ptr <= '0;
              if (!loop_en) r_state <= DRAIN;
            end else begin
              r_ptr <= r_ptr + ADDR_W'(1);
            end
          end
        end
        DRAIN: begin
          if (stop) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_empty && !r_inflight) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_sample_streamer.sv
// Scoreboard bench for audio_sample_streamer with an 8-word memory model.
module tb_audio_sample_streamer;

  localparam int NS = 8;
  localparam int AW = 18;
  localparam int SW = 16;
  localparam int FD = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic loop_en = 1'b0;
  logic busy;
  logic done;
`ifdef AUDIO_STREAMER_ATTENUATE_EN
  logic [2:0] attenuation = 3'd0;
`endif

  audio_sample_streamer_if #(.ADDR_W(AW), .SAMPLE_W(SW)) bus ();

  audio_sample_streamer #(
    .NUM_SAMPLES (NS),
    .ADDR_W      (AW),
    .SAMPLE_W    (SW),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .stop        (stop),
    .loop_en     (loop_en),
`ifdef AUDIO_STREAMER_ATTENUATE_EN
    .attenuation (attenuation),
`endif
    .busy        (busy),
    .done        (done),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Memory model: one-cycle read latency, garbage when not selected.
  bit mem_force_8000 = 1'b0;
  always @(posedge clk) begin
    if (bus.mem_chipselect)
      bus.mem_readdata <= mem_force_8000 ? 16'h8000 : 16'h1000 + bus.mem_address[15:0];
    else
      bus.mem_readdata <= 16'hDEAD;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  logic [15:0] exp_q[$];
  int issued = 0;
  int delivered = 0;
  int done_cnt = 0;
  int max_addr = 0;
  bit occ_chk = 1'b0;

  // Monitor: counts issues/transfers that take effect at the next rising edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.mem_chipselect) begin
        issued++;
        if (int'(bus.mem_address) > max_addr) max_addr = int'(bus.mem_address);
      end
      if (done) done_cnt++;
      if (bus.sample_valid && bus.sample_ready) begin
        delivered++;
        if (exp_q.size() == 0) check("sb_queue_entries", exp_q.size(), 32'd1);
        else                   check("sb_data", bus.sample_data, exp_q.pop_front());
      end
      if (occ_chk) check("occupancy_le_depth", (issued - delivered) <= FD, 1);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    issued = 0; delivered = 0; done_cnt = 0; max_addr = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic push_seq(input int n, input logic [15:0] fixed, input bit use_fixed);
    for (int i = 0; i < n; i++)
      exp_q.push_back(use_fixed ? fixed : 16'h1000 + 16'(i % NS));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check({tag, "_timeout"}, n < budget, 1);
    tick(2);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_valid"}, bus.sample_valid, 0);
    check({tag, "_data"},  bus.sample_data, 0);
    check({tag, "_cs"},    bus.mem_chipselect, 0);
    check({tag, "_addr"},  bus.mem_address, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.sample_ready = 1'b1;

    // Reset state
    reset_n = 1'b0;
    tick(3);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    tick();

    // Single-shot playback with latency checks
    clear_counts();
    loop_en = 1'b0;
    bus.sample_ready = 1'b1;
    push_seq(NS, 16'h0, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk); #1;
    check("lat_c1_cs", bus.mem_chipselect, 1);
    check("lat_c1_addr", bus.mem_address, 0);
    check("lat_c1_busy", busy, 1);
    check("lat_c1_valid", bus.sample_valid, 0);
    @(negedge clk); #1;
    check("lat_c2_valid", bus.sample_valid, 0);
    @(negedge clk); #1;
    check("lat_c3_valid", bus.sample_valid, 1);
    check("lat_c3_data", bus.sample_data, 16'h1000);
    wait_idle("single", 200);
    check("single_delivered", delivered, NS);
    check("single_queue_left", exp_q.size(), 0);
    check("single_done_cnt", done_cnt, 1);
    check("single_busy", busy, 0);
    check("single_addr_in_range", max_addr <= NS - 1, 1);

    // Loop playback: 20 samples across the wrap, no done
    clear_counts();
    loop_en = 1'b1;
    push_seq(20, 16'h0, 1'b0);
    pulse_start();
    begin
      int n = 0;
      while (delivered < 20 && n < 300) begin
        @(negedge clk); #1;
        n++;
      end
      check("loop_timeout", n < 300, 1);
    end
    @(posedge clk); #1;
    bus.sample_ready = 1'b0;
    pulse_stop();
    check("loop_stop_busy", busy, 0);
    check("loop_stop_valid", bus.sample_valid, 0);
    tick(3);
    check("loop_delivered", delivered, 20);
    check("loop_queue_left", exp_q.size(), 0);
    check("loop_done_cnt", done_cnt, 0);
    loop_en = 1'b0;

    // Backpressure: ready low for 50 cycles
    clear_counts();
    bus.sample_ready = 1'b0;
    push_seq(NS, 16'h0, 1'b0);
    pulse_start();
    tick(50);
    check("bp_issued", issued, FD);
    check("bp_valid", bus.sample_valid, 1);
    check("bp_data_held", bus.sample_data, 16'h1000);
    bus.sample_ready = 1'b1;
    wait_idle("bp", 200);
    check("bp_delivered", delivered, NS);
    check("bp_queue_left", exp_q.size(), 0);
    check("bp_done_cnt", done_cnt, 1);

    // Random ready at ~30% duty
    clear_counts();
    occ_chk = 1'b1;
    push_seq(NS, 16'h0, 1'b0);
    pulse_start();
    begin
      int n = 0;
      while (busy && n < 500) begin
        bus.sample_ready = ($urandom_range(0, 99) < 30);
        tick();
        n++;
      end
      check("rand_timeout", n < 500, 1);
    end
    bus.sample_ready = 1'b1;
    tick(2);
    occ_chk = 1'b0;
    check("rand_delivered", delivered, NS);
    check("rand_queue_left", exp_q.size(), 0);
    check("rand_done_cnt", done_cnt, 1);

    // Stop during FETCH, then restart from word 0
    clear_counts();
    bus.sample_ready = 1'b0;
    pulse_start();
    tick(4);
    check("stop_pre_busy", busy, 1);
    check("stop_pre_valid", bus.sample_valid, 1);
    pulse_stop();
    check("stop_busy", busy, 0);
    check("stop_valid", bus.sample_valid, 0);
    tick(10);
    check("stop_done_cnt", done_cnt, 0);
    check("stop_cs_idle", bus.mem_chipselect, 0);
    clear_counts();
    bus.sample_ready = 1'b1;
    push_seq(NS, 16'h0, 1'b0);
    pulse_start();
    wait_idle("restart", 200);
    check("restart_delivered", delivered, NS);
    check("restart_queue_left", exp_q.size(), 0);
    check("restart_done_cnt", done_cnt, 1);

    // Reset mid-playback
    clear_counts();
    bus.sample_ready = 1'b0;
    loop_en = 1'b1;
    pulse_start();
    tick(5);
    reset_n = 1'b0;
    tick();
    check_reset_outputs("midreset");
    reset_n = 1'b1;
    loop_en = 1'b0;
    tick(5);
    check("midreset_busy_after", busy, 0);
    check("midreset_done_cnt", done_cnt, 0);
    bus.sample_ready = 1'b1;

`ifdef AUDIO_STREAMER_ATTENUATE_EN
    // Attenuation: 16'h8000 >>> 2 = 16'hE000
    clear_counts();
    mem_force_8000 = 1'b1;
    attenuation = 3'd2;
    push_seq(NS, 16'hE000, 1'b1);
    pulse_start();
    wait_idle("atten", 200);
    check("atten_delivered", delivered, NS);
    check("atten_queue_left", exp_q.size(), 0);
    mem_force_8000 = 1'b0;
    attenuation = 3'd0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
